// File: rtl/mips_multdiv_pkg.sv
// rtl/mips_multdiv_pkg.sv - op/state encodings and iteration count for mips_multdiv
package mips_multdiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  function automatic int iter_count(input int width, input int bpc);
    return width / bpc;
  endfunction

endpackage

// File: rtl/mips_multdiv_step.sv
// rtl/mips_multdiv_step.sv - one multiply (add-or-pass, shift right) or restoring divide
// (shift left, trial subtract) iteration on the {upper, lower} accumulator.
module mips_multdiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               mode,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_out
);
  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    add_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
            + (acc_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (mode) begin
      // diff[WIDTH] set means the trial subtraction borrowed: restore
      if (diff[WIDTH])
        acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      else
        acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
    end else begin
      acc_out = {add_sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_multdiv.sv
// rtl/mips_multdiv.sv - iterative mult/multu/div/divu unit holding HI/LO
// Defining MIPS_MULTDIV_ABORT_EN adds an abort input that cancels CALC/FIX.
module mips_multdiv
  import mips_multdiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
`ifdef MIPS_MULTDIV_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int K  = iter_count(WIDTH, BITS_PER_CYCLE);
  localparam int CW = $clog2(K + 1);

  state_t             state;
  logic               div_q;
  logic               neg_res;
  logic               neg_rem;
  logic               dz_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               abort_i;
  logic               is_div;
  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

`ifdef MIPS_MULTDIV_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  always_comb begin
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    prod_fix  = neg_res ? -acc : acc;
    quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  logic [2*WIDTH-1:0] chain [0:BITS_PER_CYCLE];
  assign chain[0] = acc;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    mips_multdiv_step #(.WIDTH(WIDTH)) u_step (
      .mode    (div_q),
      .acc_in  (chain[g]),
      .opnd    (opnd),
      .acc_out (chain[g+1])
    );
  end

  assign acc_next = chain[BITS_PER_CYCLE];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      divzero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      acc     <= '0;
      opnd    <= '0;
      cnt     <= '0;
      div_q   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      // An accepted start still lets mthi/mtlo land; the result overwrites later.
      if (!busy) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            div_q   <= is_div;
            divzero <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            if (is_div && (b == '0)) begin
              // Pass-through in FIX gives hi=a, lo=all ones.
              state   <= FIX;
              dz_q    <= 1'b1;
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              acc     <= {a, {WIDTH{1'b1}}};
            end else begin
              state   <= CALC;
              dz_q    <= 1'b0;
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              acc     <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
              opnd    <= is_div ? b_mag : a_mag;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (abort_i) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(K - 1)) state <= FIX;
          end
        end
        FIX: begin
          if (abort_i) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (div_q) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
            divzero <= dz_q;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multdiv.sv
// tb/tb_mips_multdiv.sv - self-checking bench for mips_multdiv (BITS_PER_CYCLE 1 and 4)
// Abort sequence is exercised when MIPS_MULTDIV_ABORT_EN is defined.
module tb_mips_multdiv;
  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
`ifdef MIPS_MULTDIV_ABORT_EN
  logic        abort;
`endif
  logic        busy1, done1, dz1;
  logic [31:0] hi1, lo1;
  logic        busy4, done4, dz4;
  logic [31:0] hi4, lo4;

  int checks = 0;
  int errors = 0;

  mips_multdiv #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset),
`ifdef MIPS_MULTDIV_ABORT_EN
    .abort(abort),
`endif
    .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy1), .done(done1), .divzero(dz1), .hi(hi1), .lo(lo1)
  );

  mips_multdiv #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset),
`ifdef MIPS_MULTDIV_ABORT_EN
    .abort(abort),
`endif
    .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy4), .done(done4), .divzero(dz4), .hi(hi4), .lo(lo4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the MIPS definitions.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint sx, sy;
    logic [63:0] p;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    edz = 1'b0;
    case (o)
      2'd0: p = sx * sy;
      2'd1: p = {32'd0, x} * {32'd0, y};
      2'd2: if (y == 0) begin p = {x, 32'hFFFFFFFF}; edz = 1'b1; end
            else p = {32'(sx % sy), 32'(sx / sy)};
      default: if (y == 0) begin p = {x, 32'hFFFFFFFF}; edz = 1'b1; end
               else p = {x % y, x / y};
    endcase
    eh = p[63:32];
    el = p[31:0];
  endfunction

  task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz, input bit intf);
    int lat1, lat4, bcnt, exp1, exp4;
    exp1 = edz ? 1 : 33;
    exp4 = edz ? 1 : 9;
    lat1 = -1;
    lat4 = -1;
    bcnt = 0;
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "/divzero_clr"}, dz1, 0);
    for (int n = 0; n < 60 && (lat1 < 0 || lat4 < 0); n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (busy1) bcnt++;
      if (done1 && lat1 < 0) begin
        lat1 = n;
        chk({nm, "/hi1"}, hi1, eh);
        chk({nm, "/lo1"}, lo1, el);
        chk({nm, "/dz1"}, dz1, edz);
      end
      if (done4 && lat4 < 0) begin
        lat4 = n;
        chk({nm, "/hi4"}, hi4, eh);
        chk({nm, "/lo4"}, lo4, el);
        chk({nm, "/dz4"}, dz4, edz);
      end
      if (intf && n == 4) begin
        start = 1'b1; op = 2'd3; a = 32'hDEAD0000; b = 32'h3;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h12345678;
      end
      if (intf && n == 5) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
    end
    chk({nm, "/latency1"}, lat1, exp1);
    chk({nm, "/latency4"}, lat4, exp4);
    chk({nm, "/busy_cycles1"}, bcnt, exp1);
  endtask

  vec_t vt[9];
  logic [1:0]  ro;
  logic [31:0] rx, ry, reh, rel;
  logic        redz;

  initial begin
    vt[0] = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vt[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vt[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[3] = '{2'd3, 32'h80000000, 32'h00000003, 32'h00000002, 32'h2AAAAAAA, 1'b0};
    vt[4] = '{2'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    vt[5] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vt[6] = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vt[7] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vt[8] = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};

    reset = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
`ifdef MIPS_MULTDIV_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset/busy", {busy1, busy4}, 2'b00);
    chk("reset/done", {done1, done4}, 2'b00);
    chk("reset/divzero", {dz1, dz4}, 2'b00);
    chk("reset/hi", {hi1, hi4}, 64'd0);
    chk("reset/lo", {lo1, lo4}, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++)
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].dz, i == 1);

    @(posedge clk); #1;
    hi_we = 1'b1; wdata = 32'h12345678;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi/hi1", hi1, 32'h12345678);
    chk("mthi/hi4", hi4, 32'h12345678);
    lo_we = 1'b1; wdata = 32'h9ABCDEF0;
    @(posedge clk); #1;
    lo_we = 1'b0;
    chk("mtlo/lo1", lo1, 32'h9ABCDEF0);
    chk("mtlo/hi_kept", hi1, 32'h12345678);

    op = 2'd0; a = 32'd5; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_calc/busy", {busy1, busy4}, 2'b00);
    chk("rst_calc/hi", {hi1, hi4}, 64'd0);
    chk("rst_calc/lo", {lo1, lo4}, 64'd0);
    chk("rst_calc/done_dz", {done1, done4, dz1, dz4}, 4'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_calc/idle_after", {busy1, busy4}, 2'b00);

`ifdef MIPS_MULTDIV_ABORT_EN
    begin
      bit seen;
      seen = 1'b0;
      hi_we = 1'b1; wdata = 32'hAAAA5555;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0F0F0F0F;
      @(posedge clk); #1;
      lo_we = 1'b0; op = 2'd0; a = 32'd3; b = 32'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort/busy", {busy1, busy4}, 2'b00);
      for (int n = 0; n < 40; n++) begin
        if (done1 || done4) seen = 1'b1;
        @(posedge clk); #1;
      end
      chk("abort/no_done", seen, 1'b0);
      chk("abort/hi", {hi1, hi4}, {32'hAAAA5555, 32'hAAAA5555});
      chk("abort/lo", {lo1, lo4}, {32'h0F0F0F0F, 32'h0F0F0F0F});
    end
`endif

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: ry = ry & 32'hF;
        2: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
        default: ;
      endcase
      model(ro, rx, ry, reh, rel, redz);
      do_op($sformatf("rnd%0d", i), ro, rx, ry, reh, rel, redz, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
